// File: rtl/serial_in_parallel_out_ble_if.sv
// serial_in_parallel_out_ble_if
//   Bundles the serial input side and the parallel output side of the BLE
//   receive deserializer.
//   master : drives data_in/valid_in/flush/rd/ovf_clr, observes the outputs
//            (PHY bit source plus downstream consumer).
//   slave  : the deserializer itself.
//   Signals:
//     data_in   - serial bit, meaningful only with valid_in
//     valid_in  - qualifies data_in, one bit per cycle
//     flush     - one-cycle pulse, emit partial word zero-padded
//     rd        - consumer accepts data_out while valid_out is high
//     ovf_clr   - clears the sticky overflow flag
//     data_out  - assembled word in the holding register
//     valid_out - data_out holds an unread word
//     done      - one-cycle pulse when a word is loaded into data_out
//     bit_cnt   - bits collected in the current word
//     overflow  - sticky, a completed word was dropped
interface serial_in_parallel_out_ble_if #(
  parameter int DATA  = 32,
  parameter int CNT_W = $clog2(DATA)
);
  logic             data_in;
  logic             valid_in;
  logic             flush;
  logic             rd;
  logic             ovf_clr;
  logic [DATA-1:0]  data_out;
  logic             valid_out;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;
  logic             overflow;

  modport master (
    output data_in, valid_in, flush, rd, ovf_clr,
    input  data_out, valid_out, done, bit_cnt, overflow
  );

  modport slave (
    input  data_in, valid_in, flush, rd, ovf_clr,
    output data_out, valid_out, done, bit_cnt, overflow
  );
endinterface

// File: rtl/serial_in_parallel_out_ble.sv
// serial_in_parallel_out_ble
//   BLE PHY receive deserializer. Collects qualified serial bits LSB first
//   into DATA-bit words and presents each word in a holding register with a
//   valid/read handshake. Bit order mirrors the PHY transmit serializer so a
//   serialized word is reconstructed bit-exactly.
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous, active-high; clears all state
//     bus   - serial_in_parallel_out_ble_if.slave (see interface header)
module serial_in_parallel_out_ble #(
  parameter int DATA = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  serial_in_parallel_out_ble_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(DATA - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } state_t;

  state_t           state, state_nxt;

  logic [DATA-1:0]  shift_reg;
  logic [DATA-1:0]  data_out_q;
  logic             valid_out_q;
  logic             done_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             overflow_q;

  logic             complete;
  logic             flush_act;
  logic             emit;
  logic             load;
  logic             drop;
  logic [DATA-1:0]  word_p0;

  // Keep the bits already collected below pos, optionally insert the bit
  // arriving this cycle at pos, and force everything above to zero. A full
  // word is simply the case pos = DATA-1 with a valid bit.
  function automatic logic [DATA-1:0] pad_word(
    input logic [DATA-1:0]  sreg,
    input logic [CNT_W-1:0] pos,
    input logic             bit_in,
    input logic             bit_vld
  );
    logic [DATA-1:0] one;
    logic [DATA-1:0] mask;
    logic [DATA-1:0] merged;
    one    = {{(DATA-1){1'b0}}, 1'b1};
    mask   = (one << pos) - one;
    merged = sreg & mask;
    if (bit_vld) begin
      merged = merged | ({{(DATA-1){1'b0}}, bit_in} << pos);
    end
    return merged;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a flush that arrives together with the first bit
  // emits a one-bit word and never leaves IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.valid_in && !emit) state_nxt = ASSEMBLE;
      ASSEMBLE: if (emit)                  state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    complete  = bus.valid_in && (bit_cnt_q == LAST_POS);
    // Flush only matters when there is at least one bit to emit; a flush
    // coinciding with the final bit collapses into that single completion.
    flush_act = bus.flush && ((state == ASSEMBLE) || bus.valid_in);
    emit      = complete || flush_act;
    load      = emit && (!valid_out_q || bus.rd);
    drop      = emit && valid_out_q && !bus.rd;
    word_p0   = pad_word(shift_reg, bit_cnt_q, bus.data_in, bus.valid_in);
  end

  // p0 -> holding register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg   <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      done_q      <= 1'b0;
      bit_cnt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (bus.valid_in) begin
        shift_reg[bit_cnt_q] <= bus.data_in;
      end

      if (emit) begin
        bit_cnt_q <= '0;
      end else if (bus.valid_in) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end

      if (load) begin
        data_out_q <= word_p0;
      end

      if (load) begin
        valid_out_q <= 1'b1;
      end else if (bus.rd) begin
        valid_out_q <= 1'b0;
      end

      done_q <= load;

      // A new drop outranks a simultaneous clear.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.done      = done_q;
  assign bus.bit_cnt   = bit_cnt_q;
  assign bus.overflow  = overflow_q;

endmodule
